shift_add_mult: RTL and testbench



---
 rtl/mult_pkg.sv | 21 ++
 rtl/mul_sign_adj.sv | 13 +
 rtl/shift_add_mult.sv | 121 ++++++++++++
 tb/tb_shift_add_mult.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier family: FSM state
// encoding and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= value; callers pass CW+1 to size the iteration counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_sign_adj.sv
// Conditional two's-complement negate: yields -val_i when neg_i is set, val_i otherwise.
// Used both to take operand magnitudes and to restore the sign of the product.
module mul_sign_adj #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one add/shift per cycle over CW iterations,
// optional two's-complement mode via sign-magnitude conversion, registered product.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int MW        = 16,
    parameter int CW        = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             St,
    input  logic             Sgn,
    input  logic [MW-1:0]    Mult,
    input  logic [CW-1:0]    Mcand,
    output logic [MW+CW-1:0] product,
    output logic             Done,
    output logic             Busy
);

    localparam int PW   = MW + CW;
    localparam int CNTW = clog2(CW + 1);

    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [PW:0]     acc_q;
    logic [PW:0]     acc_d;
    logic [PW:0]     acc_sum;
    logic [MW-1:0]   mult_q;
    logic            neg_q;
    logic [PW-1:0]   product_q;
    logic            done_q;
    logic            busy_q;

    logic            signed_eff;
    logic            mult_neg;
    logic            mcand_neg;
    logic [MW-1:0]   mult_abs;
    logic [CW-1:0]   mcand_abs;
    logic [PW-1:0]   prod_adj;

    assign signed_eff = Sgn & SIGNED_EN;
    assign mult_neg   = signed_eff & Mult[MW-1];
    assign mcand_neg  = signed_eff & Mcand[CW-1];

    // Magnitudes are read as unsigned, so -2**(W-1) maps cleanly onto 2**(W-1).
    mul_sign_adj #(.W(MW)) u_abs_mult (
        .val_i (Mult),
        .neg_i (mult_neg),
        .val_o (mult_abs)
    );

    mul_sign_adj #(.W(CW)) u_abs_mcand (
        .val_i (Mcand),
        .neg_i (mcand_neg),
        .val_o (mcand_abs)
    );

    mul_sign_adj #(.W(PW)) u_neg_prod (
        .val_i (acc_q[PW-1:0]),
        .neg_i (neg_q),
        .val_o (prod_adj)
    );

    // The top acc bit is always zero entering an iteration, so the upper add cannot overflow.
    always_comb begin
        acc_sum = acc_q;
        if (acc_q[0]) begin
            acc_sum[PW:CW] = {1'b0, acc_q[PW-1:CW]} + {1'b0, mult_q};
        end
        acc_d = {1'b0, acc_sum[PW:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mult_q    <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (St) begin
                        mult_q  <= mult_abs;
                        acc_q   <= {{(MW + 1){1'b0}}, mcand_abs};
                        neg_q   <= mult_neg ^ mcand_neg;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(CW - 1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    product_q <= prod_adj;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign Done    = done_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: default signed-capable build plus an
// unsigned-only build driven by the same stimulus.
module tb_shift_add_mult;

    localparam int MW = 16;
    localparam int CW = 4;
    localparam int PW = MW + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          St = 1'b0;
    logic          Sgn = 1'b0;
    logic [MW-1:0] Mult = '0;
    logic [CW-1:0] Mcand = '0;
    logic [PW-1:0] product;
    logic          Done;
    logic          Busy;
    logic [PW-1:0] product_us;
    logic          done_us;
    logic          busy_us;

    int checks = 0;
    int failures = 0;

    shift_add_mult #(.MW(MW), .CW(CW), .SIGNED_EN(1'b1)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .St      (St),
        .Sgn     (Sgn),
        .Mult    (Mult),
        .Mcand   (Mcand),
        .product (product),
        .Done    (Done),
        .Busy    (Busy)
    );

    shift_add_mult #(.MW(MW), .CW(CW), .SIGNED_EN(1'b0)) u_dut_us (
        .clk     (clk),
        .rst     (rst),
        .St      (St),
        .Sgn     (Sgn),
        .Mult    (Mult),
        .Mcand   (Mcand),
        .product (product_us),
        .Done    (done_us),
        .Busy    (busy_us)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start at the next edge (E0), then follow the op through to its Done cycle.
    // Returns #1 after edge E(CW+1), with Done expected high.
    task automatic do_mult(input string tag, input logic sgn, input logic [MW-1:0] m,
                           input logic [CW-1:0] c, input logic [PW-1:0] exp, input bit hold);
        Sgn = sgn;
        Mult = m;
        Mcand = c;
        St = 1'b1;
        @(posedge clk); #1;
        if (!hold) St = 1'b0;
        check({tag, "_busy_e0"}, {31'b0, Busy}, 32'd1);
        check({tag, "_done_e0"}, {31'b0, Done}, 32'd0);
        for (int k = 1; k <= CW; k++) begin
            @(posedge clk); #1;
            check({tag, "_busy_calc"}, {31'b0, Busy}, 32'd1);
            check({tag, "_done_early"}, {31'b0, Done}, 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {31'b0, Done}, 32'd1);
        check({tag, "_busy_done"}, {31'b0, Busy}, 32'd0);
        check({tag, "_product"}, {12'b0, product}, {12'b0, exp});
        $display("txn %s: Mult=%h Mcand=%h Sgn=%0d product=%h", tag, m, c, sgn, product);
    endtask

    initial begin
        int done_cnt;

        // Reset state while rst is held
        #12;
        check("rst_product", {12'b0, product}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", {31'b0, Busy}, 32'd0);

        // Back-to-back with St held high
        do_mult("u9x5", 1'b0, 16'd9, 4'd5, 20'd45, 1'b1);
        Mult = 16'd11;
        Mcand = 4'd15;
        do_mult("u11x15", 1'b0, 16'd11, 4'd15, 20'd165, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, Done}, 32'd0);
        check("product_hold", {12'b0, product}, 32'd165);

        // Signed mode; unsigned-only build sees the same bits as unsigned
        do_mult("s_m3x5", 1'b1, 16'hFFFD, 4'd5, 20'hFFFF1, 1'b0);
        check("us_build_product", {12'b0, product_us}, 32'h4FFF1);
        check("us_build_done", {31'b0, done_us}, 32'd1);
        check("us_build_busy", {31'b0, busy_us}, 32'd0);
        do_mult("s_7xm2", 1'b1, 16'd7, 4'hE, 20'hFFFF2, 1'b0);

        // Extremes and zero operands
        do_mult("u_max", 1'b0, 16'hFFFF, 4'hF, 20'hEFFF1, 1'b0);
        do_mult("s_min", 1'b1, 16'h8000, 4'h8, 20'h40000, 1'b0);
        do_mult("u_0x5", 1'b0, 16'd0, 4'd5, 20'd0, 1'b0);
        do_mult("u_3x3", 1'b0, 16'd3, 4'd3, 20'd9, 1'b0);
        do_mult("u_1234x0", 1'b0, 16'd1234, 4'd0, 20'd0, 1'b0);

        // St pulse and operand changes mid-operation are ignored
        Sgn = 1'b0;
        Mult = 16'd11;
        Mcand = 4'd15;
        St = 1'b1;
        @(posedge clk); #1;
        St = 1'b0;
        done_cnt = 0;
        @(posedge clk); #1;
        St = 1'b1;
        Sgn = 1'b1;
        Mult = 16'h1234;
        Mcand = 4'd3;
        @(posedge clk); #1;
        St = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (Done) done_cnt++;
        end
        check("midop_done_count", done_cnt, 32'd1);
        check("midop_product", {12'b0, product}, 32'd165);
        $display("txn midop: product=%h dones=%0d", product, done_cnt);

        // Asynchronous reset two cycles into CALC aborts the operation
        Sgn = 1'b0;
        Mult = 16'd9;
        Mcand = 4'd5;
        St = 1'b1;
        @(posedge clk); #1;
        St = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_product", {12'b0, product}, 32'd0);
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_done", {31'b0, Done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (Done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_idle_busy", {31'b0, Busy}, 32'd0);
        $display("txn abort: product=%h dones=%0d", product, done_cnt);
        do_mult("restart_9x5", 1'b0, 16'd9, 4'd5, 20'd45, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
